// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl -- multi-cycle control FSM for a small RV32 datapath.
//
// Sequence per instruction: FETCH -> EXEC (ExecWait cycles) -> [MEM] -> WB.
// Unsupported encodings lock the controller in TRAP until res.
//
// Ports
//   clk, res                  clock, synchronous active-high reset
//   instr_read/req/valid      instruction fetch handshake
//   mem_req/we/valid          data-memory handshake
//   branch_taken              ALU compare result, used only in BRANCH WB
//   alusrc_pc .. regwrite     datapath controls
//   jump, linktoreg           PC <= ALU result, PC+4 to rd
//   illegal                   sticky unsupported-instruction flag
module mcycle_ctrl #(
  parameter int unsigned ExecWait = 2,
  parameter int unsigned CntBits  = 2
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] instr_read,
  output logic        instr_req,
  input  logic        instr_valid,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_valid,
  input  logic        branch_taken,
  output logic        alusrc_pc,
  output logic        immediatetoreg,
  output logic        pc_enable,
  output logic        branch,
  output logic        memtoreg,
  output logic        memwrite,
  output logic        alusrc,
  output logic        regwrite,
  output logic        jump,
  output logic        linktoreg,
  output logic        illegal
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_EXEC  = 3'd1;
  localparam logic [2:0] S_MEM   = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_TRAP  = 3'd4;

  localparam logic [3:0] C_NONE   = 4'd0;
  localparam logic [3:0] C_LOAD   = 4'd1;
  localparam logic [3:0] C_OP_IMM = 4'd2;
  localparam logic [3:0] C_AUIPC  = 4'd3;
  localparam logic [3:0] C_STORE  = 4'd4;
  localparam logic [3:0] C_OP     = 4'd5;
  localparam logic [3:0] C_LUI    = 4'd6;
  localparam logic [3:0] C_BRANCH = 4'd7;
  localparam logic [3:0] C_JALR   = 4'd8;
  localparam logic [3:0] C_JAL    = 4'd9;

  logic [2:0]         state;
  logic [3:0]         cls;
  logic [3:0]         dec_cls;
  logic [CntBits-1:0] cnt;
  logic               in_flight;

  // Only the opcode field matters to this controller.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_read[31:7];

  always_comb begin
    dec_cls = C_NONE;
    if (instr_read[1:0] == 2'b11) begin
      case (instr_read[6:2])
        5'b00000: dec_cls = C_LOAD;
        5'b00100: dec_cls = C_OP_IMM;
        5'b00101: dec_cls = C_AUIPC;
        5'b01000: dec_cls = C_STORE;
        5'b01100: dec_cls = C_OP;
        5'b01101: dec_cls = C_LUI;
        5'b11000: dec_cls = C_BRANCH;
        5'b11001: dec_cls = C_JALR;
        5'b11011: dec_cls = C_JAL;
        default:  dec_cls = C_NONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state <= S_FETCH;
      cls   <= C_NONE;
      cnt   <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (instr_valid) begin
            if (dec_cls == C_NONE) begin
              state <= S_TRAP;
            end else begin
              cls   <= dec_cls;
              // Counter counts down to zero, so EXEC lasts ExecWait cycles.
              cnt   <= CntBits'(ExecWait - 1);
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (cnt == '0) begin
            state <= (cls == C_LOAD || cls == C_STORE) ? S_MEM : S_WB;
          end else begin
            cnt <= cnt - CntBits'(1);
          end
        end
        S_MEM:   if (mem_valid) state <= S_WB;
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

  assign in_flight = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

  always_comb begin
    instr_req      = (state == S_FETCH);
    illegal        = (state == S_TRAP);
    mem_req        = (state == S_MEM);
    mem_we         = (state == S_MEM) && (cls == C_STORE);
    memwrite       = (state == S_MEM) && (cls == C_STORE);
    pc_enable      = (state == S_WB);
    regwrite       = 1'b0;
    branch         = 1'b0;
    jump           = 1'b0;
    alusrc         = 1'b0;
    alusrc_pc      = 1'b0;
    immediatetoreg = 1'b0;
    memtoreg       = 1'b0;
    linktoreg      = 1'b0;
    if (in_flight) begin
      alusrc         = (cls == C_OP_IMM) || (cls == C_LOAD) || (cls == C_STORE) ||
                       (cls == C_AUIPC)  || (cls == C_JAL)  || (cls == C_JALR);
      alusrc_pc      = (cls == C_AUIPC) || (cls == C_JAL);
      immediatetoreg = (cls == C_LUI);
      memtoreg       = (cls == C_LOAD);
      linktoreg      = (cls == C_JAL) || (cls == C_JALR);
    end
    if (state == S_WB) begin
      regwrite = (cls == C_OP)  || (cls == C_OP_IMM) || (cls == C_LUI) ||
                 (cls == C_AUIPC) || (cls == C_LOAD) || (cls == C_JAL) ||
                 (cls == C_JALR);
      branch   = (cls == C_BRANCH) && branch_taken;
      jump     = (cls == C_JAL) || (cls == C_JALR);
    end
  end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Testbench for mcycle_ctrl: expected output vectors are pushed to a
// scoreboard queue as each cycle's stimulus is driven and popped/compared
// on the following falling edge.
module tb_mcycle_ctrl;

  localparam int unsigned EW = 2;

  // Phases and instruction classes as seen by the bench.
  localparam int P_FETCH = 0, P_EXEC = 1, P_MEM = 2, P_WB = 3, P_TRAP = 4;
  localparam int K_LOAD = 1, K_OPIMM = 2, K_AUIPC = 3, K_STORE = 4, K_OP = 5,
                 K_LUI = 6, K_BRANCH = 7, K_JALR = 8, K_JAL = 9;

  logic        clk = 1'b0;
  logic        res;
  logic [31:0] instr_read;
  logic        instr_req, instr_valid;
  logic        mem_req, mem_we, mem_valid;
  logic        branch_taken;
  logic        alusrc_pc, immediatetoreg, pc_enable, branch, memtoreg;
  logic        memwrite, alusrc, regwrite, jump, linktoreg, illegal;

  mcycle_ctrl #(.ExecWait(EW), .CntBits(2)) dut (
    .clk(clk), .res(res),
    .instr_read(instr_read), .instr_req(instr_req), .instr_valid(instr_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_valid(mem_valid),
    .branch_taken(branch_taken),
    .alusrc_pc(alusrc_pc), .immediatetoreg(immediatetoreg), .pc_enable(pc_enable),
    .branch(branch), .memtoreg(memtoreg), .memwrite(memwrite), .alusrc(alusrc),
    .regwrite(regwrite), .jump(jump), .linktoreg(linktoreg), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Bit order: req mreq we mwr pce rw br jmp als apc imm m2r lnk ill
  logic [13:0] obs;
  assign obs = {instr_req, mem_req, mem_we, memwrite, pc_enable, regwrite, branch,
                jump, alusrc, alusrc_pc, immediatetoreg, memtoreg, linktoreg, illegal};

  typedef struct {
    string       tag;
    logic [13:0] v;
  } sb_item_t;

  sb_item_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] exp_out(input int ph, input int k, input logic bt);
    logic [13:0] e;
    e = '0;
    case (ph)
      P_FETCH: e[13] = 1'b1;
      P_TRAP:  e[0]  = 1'b1;
      default: begin
        e[5] = (k == K_OPIMM) || (k == K_LOAD) || (k == K_STORE) ||
               (k == K_AUIPC) || (k == K_JAL) || (k == K_JALR);
        e[4] = (k == K_AUIPC) || (k == K_JAL);
        e[3] = (k == K_LUI);
        e[2] = (k == K_LOAD);
        e[1] = (k == K_JAL) || (k == K_JALR);
        if (ph == P_MEM) begin
          e[12] = 1'b1;
          e[11] = (k == K_STORE);
          e[10] = (k == K_STORE);
        end
        if (ph == P_WB) begin
          e[9] = 1'b1;
          e[8] = (k != K_STORE) && (k != K_BRANCH);
          e[7] = (k == K_BRANCH) && bt;
          e[6] = (k == K_JAL) || (k == K_JALR);
        end
      end
    endcase
    return e;
  endfunction

  // Inputs for this cycle are already driven; queue the expectation,
  // compare on the falling edge, then move 1 time unit past the next rise.
  task automatic step(input string tag, input logic [13:0] e);
    sb_item_t it;
    sb.push_back('{tag, e});
    @(negedge clk);
    it = sb.pop_front();
    check(it.tag, obs, it.v);
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    instr_valid  = 1'($urandom);
    instr_read   = $urandom;
    mem_valid    = 1'($urandom);
    branch_taken = 1'($urandom);
  endtask

  task automatic run_instr(input string tag, input logic [31:0] ins, input int k,
                           input int unsigned mem_wait, input logic bt);
    res = 1'b0;
    noise();
    instr_valid = 1'b1;
    instr_read  = ins;
    step($sformatf("%s_fetch", tag), exp_out(P_FETCH, k, bt));
    for (int unsigned i = 0; i < EW; i++) begin
      noise();
      step($sformatf("%s_exec%0d", tag, i), exp_out(P_EXEC, k, bt));
    end
    if (k == K_LOAD || k == K_STORE) begin
      for (int unsigned i = 0; i <= mem_wait; i++) begin
        noise();
        mem_valid = (i == mem_wait);
        step($sformatf("%s_mem%0d", tag, i), exp_out(P_MEM, k, bt));
      end
    end
    noise();
    if (k == K_BRANCH) branch_taken = bt;
    step($sformatf("%s_wb", tag), exp_out(P_WB, k, bt));
    noise();
    instr_valid = 1'b0;
    step($sformatf("%s_next", tag), exp_out(P_FETCH, k, bt));
  endtask

  initial begin
    res = 1'b1;
    noise();
    @(posedge clk); #1;
    @(posedge clk); #1;
    res = 1'b0;
    instr_valid = 1'b0;
    step("reset_fetch", exp_out(P_FETCH, 0, 1'b0));

    run_instr("addi",  32'h00100093, K_OPIMM, 0, 1'b0);
    run_instr("lw",    32'h00002083, K_LOAD,  3, 1'b0);
    run_instr("sw",    32'h00112023, K_STORE, 0, 1'b0);
    run_instr("beq_t", 32'h00000063, K_BRANCH, 0, 1'b1);
    run_instr("beq_n", 32'h00000063, K_BRANCH, 0, 1'b0);
    run_instr("jal",   32'h008000EF, K_JAL,   0, 1'b0);
    run_instr("jalr",  32'h000080E7, K_JALR,  0, 1'b0);
    run_instr("add",   32'h00208133, K_OP,    0, 1'b0);
    run_instr("lui",   32'h000010B7, K_LUI,   0, 1'b0);
    run_instr("auipc", 32'h00001097, K_AUIPC, 0, 1'b0);
    run_instr("lw_w1", 32'h00002083, K_LOAD,  1, 1'b0);

    // All-zero word: trap held for 20 cycles regardless of inputs.
    instr_valid = 1'b1;
    instr_read  = 32'h00000000;
    step("ill_fetch", exp_out(P_FETCH, 0, 1'b0));
    for (int unsigned i = 0; i < 20; i++) begin
      noise();
      step($sformatf("trap%0d", i), exp_out(P_TRAP, 0, 1'b0));
    end
    noise();
    res = 1'b1;
    step("trap_res", exp_out(P_TRAP, 0, 1'b0));
    res = 1'b0;
    instr_valid = 1'b0;
    step("trap_exit", exp_out(P_FETCH, 0, 1'b0));

    // Bad low bits and an unsupported opcode also trap.
    instr_valid = 1'b1;
    instr_read  = 32'h00100090;
    step("lowbits_fetch", exp_out(P_FETCH, 0, 1'b0));
    noise();
    step("lowbits_trap", exp_out(P_TRAP, 0, 1'b0));
    res = 1'b1;
    step("lowbits_res", exp_out(P_TRAP, 0, 1'b0));
    res = 1'b0;
    instr_valid = 1'b1;
    instr_read  = 32'h00000073;
    step("sys_fetch", exp_out(P_FETCH, 0, 1'b0));
    noise();
    step("sys_trap", exp_out(P_TRAP, 0, 1'b0));

    // Reset wins over a fetch of an illegal word.
    res = 1'b1;
    step("sys_res", exp_out(P_TRAP, 0, 1'b0));
    instr_valid = 1'b1;
    instr_read  = 32'h00000000;
    step("res_vs_fetch", exp_out(P_FETCH, 0, 1'b0));
    res = 1'b0;
    instr_valid = 1'b0;
    step("res_vs_fetch_after", exp_out(P_FETCH, 0, 1'b0));

    // Reset in the middle of MEM.
    instr_valid = 1'b1;
    instr_read  = 32'h00002083;
    step("rmem_fetch", exp_out(P_FETCH, K_LOAD, 1'b0));
    for (int unsigned i = 0; i < EW; i++) begin
      noise();
      step($sformatf("rmem_exec%0d", i), exp_out(P_EXEC, K_LOAD, 1'b0));
    end
    noise();
    mem_valid = 1'b0;
    step("rmem_mem0", exp_out(P_MEM, K_LOAD, 1'b0));
    mem_valid = 1'b1;
    res = 1'b1;
    step("rmem_mem_res", exp_out(P_MEM, K_LOAD, 1'b0));
    res = 1'b0;
    instr_valid = 1'b0;
    step("rmem_after", exp_out(P_FETCH, 0, 1'b0));

    // Reset in the middle of EXEC.
    instr_valid = 1'b1;
    instr_read  = 32'h00112023;
    step("rexe_fetch", exp_out(P_FETCH, K_STORE, 1'b0));
    noise();
    res = 1'b1;
    step("rexe_exec_res", exp_out(P_EXEC, K_STORE, 1'b0));
    res = 1'b0;
    instr_valid = 1'b0;
    step("rexe_after", exp_out(P_FETCH, 0, 1'b0));

    // Normal operation resumes after the mid-flight reset.
    run_instr("addi2", 32'h00100093, K_OPIMM, 0, 1'b0);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mcycle_ctrl.md
MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 Parameter ExecWait, default 2: number of EXEC cycles per instruction, legal range 1..(2**CntBits)-1.
REQ-002 Parameter CntBits, default 2: width of the internal EXEC cycle counter.
REQ-003 Port clk input 1: single clock; all state changes occur on its rising edge.
REQ-004 Port res input 1: reset, synchronous and active-high.
REQ-005 Port instr_read input 32, instr_req output 1, instr_valid input 1: instruction fetch handshake.
REQ-006 Port mem_req output 1, mem_we output 1, mem_valid input 1: data-memory handshake.
REQ-007 Port branch_taken input 1: ALU compare result for the current BRANCH.
REQ-008 Ports alusrc_pc, immediatetoreg, pc_enable, branch, memtoreg, memwrite, alusrc, regwrite output 1 each: datapath controls.
REQ-009 Ports jump output 1 (PC <= ALU result) and linktoreg output 1 (PC+4 to rd).
REQ-010 Port illegal output 1: sticky unsupported-instruction flag.

Function
REQ-011 States SHALL be FETCH, EXEC, MEM, WB and TRAP; a registered 4-bit class is latched at decode.
REQ-012 FETCH: instr_req=1; when instr_valid=1, decode instr_read[6:2] with instr_read[1:0]==2'b11, latch class, load counter, go to EXEC.
REQ-013 Supported [6:2] codes: LOAD 00000, OP_IMM 00100, AUIPC 00101, STORE 01000, OP 01100, LUI 01101, BRANCH 11000, JALR 11001, JAL 11011.
REQ-014 Any other code, or [1:0]!=2'b11, SHALL go to TRAP; illegal=1 from the next cycle.
REQ-015 TRAP SHALL hold with all outputs 0 except illegal=1 until res; no simulation abort.
REQ-016 EXEC SHALL last exactly ExecWait cycles, then go to MEM for LOAD/STORE, otherwise to WB.
REQ-017 MEM: mem_req=1 (mem_we=1 and memwrite=1 for STORE) until mem_valid=1, then go to WB; no timeout.
REQ-018 WB SHALL last one cycle with pc_enable=1, then return to FETCH.
REQ-019 regwrite=1 only in WB for OP, OP_IMM, LUI, AUIPC, LOAD, JAL, JALR.
REQ-020 branch=1 only in WB for BRANCH with branch_taken=1, sampled in that cycle.
REQ-021 jump=1 only in WB for JAL and JALR.
REQ-022 From EXEC through WB, per class: alusrc=1 for OP_IMM, LOAD, STORE, AUIPC, JAL, JALR; alusrc_pc=1 for AUIPC, JAL; immediatetoreg=1 for LUI; memtoreg=1 for LOAD; linktoreg=1 for JAL, JALR.
REQ-023 All outputs not enabled by REQ-012..022 SHALL be 0; outputs are decoded combinationally from state and class.
REQ-024 instr_valid outside FETCH, mem_valid outside MEM and branch_taken outside BRANCH WB SHALL be ignored.
REQ-025 Latency from instr_valid accept to next instr_req: ExecWait+2 cycles for non-memory classes; plus MEM wait for LOAD/STORE.

Reset
REQ-026 res=1 SHALL override all other events in the same cycle.
REQ-027 res=1 from any state, including mid-EXEC, MEM or TRAP, SHALL give FETCH, cleared class/counter, illegal=0 on the next cycle.
REQ-028 While in post-reset FETCH: instr_req=1, all other outputs 0.

Verification
REQ-029 ExecWait=2; ADDI 0x00100093 valid cycle 0 -> EXEC cycles 1-2 with alusrc=1; WB cycle 3: regwrite=1, pc_enable=1; instr_req=1 cycle 4.
REQ-030 LW 0x00002083, mem_valid 3 cycles after MEM entry -> mem_req=1, mem_we=0 cycles 3-6; WB cycle 7: memtoreg=1, regwrite=1.
REQ-031 SW 0x00112023, mem_valid at first MEM cycle -> mem_we=1, memwrite=1 cycle 3; WB cycle 4: regwrite=0, pc_enable=1.
REQ-032 BEQ 0x00000063 with branch_taken=1 in WB -> branch=1, pc_enable=1, regwrite=0; repeat with branch_taken=0 -> branch=0.
REQ-033 JAL 0x008000EF -> alusrc_pc=1, alusrc=1, linktoreg=1 in EXEC/WB; WB: jump=1, regwrite=1.
REQ-034 0x00000000 -> illegal=1, instr_req=0 held 20 cycles; res pulse -> illegal=0, instr_req=1 the cycle after; res mid-MEM -> FETCH, mem_req=0 next cycle.
